// File: rtl/door_ctrl.sv
// Door sequencer: times opening, hold and closing, drives the 2-bit door animation stage.
// Registered outputs only; STEP_CYCLES per animation step, HOLD_CYCLES fully open.
module door_ctrl #(
  parameter int unsigned STEP_CYCLES = 32'd12_500_000,
  parameter int unsigned HOLD_CYCLES = 32'd100_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       open_req,
  input  logic       reopen_btn,
  input  logic       close_btn,
  input  logic       moving,
  output logic [1:0] dispStage,
  output logic       door_closed,
  output logic       close_done
);

  typedef enum logic [1:0] {CLOSED, OPENING, HOLD, CLOSING} state_t;

  localparam logic [31:0] STEP_LAST = 32'(STEP_CYCLES - 32'd1);
  localparam logic [31:0] HOLD_LAST = 32'(HOLD_CYCLES - 32'd1);

  state_t      state_q, state_d;
  logic [1:0]  stage_q, stage_d;
  logic [31:0] timer_q, timer_d;
  logic        close_done_q, close_done_d;
  logic        req;

  assign req = open_req | reopen_btn;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= CLOSED;
      stage_q      <= 2'b00;
      timer_q      <= '0;
      close_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      stage_q      <= stage_d;
      timer_q      <= timer_d;
      close_done_q <= close_done_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    stage_d      = stage_q;
    timer_d      = timer_q + 32'd1;
    close_done_d = 1'b0;
    case (state_q)
      CLOSED: begin
        timer_d = '0;
        if (req && !moving) state_d = OPENING;
      end
      OPENING: begin
        // A reversal caught at stage 11 goes straight to HOLD so the stage never wraps.
        if (stage_q == 2'b11) begin
          state_d = HOLD;
          timer_d = '0;
        end else if (timer_q == STEP_LAST) begin
          stage_d = stage_q + 2'd1;
          timer_d = '0;
          if (stage_q == 2'b10) state_d = HOLD;
        end
      end
      HOLD: begin
        if (req) begin
          timer_d = '0;
        end else if (close_btn || (timer_q == HOLD_LAST)) begin
          state_d = CLOSING;
          timer_d = '0;
        end
      end
      CLOSING: begin
        if (req) begin
          state_d = OPENING;
          timer_d = '0;
        end else if (stage_q == 2'b00) begin
          state_d = CLOSED;
          timer_d = '0;
        end else if (timer_q == STEP_LAST) begin
          stage_d = stage_q - 2'd1;
          timer_d = '0;
          if (stage_q == 2'b01) begin
            state_d      = CLOSED;
            close_done_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = CLOSED;
        stage_d = 2'b00;
        timer_d = '0;
      end
    endcase
  end

  always_comb begin
    dispStage   = stage_q;
    door_closed = (state_q == CLOSED);
    close_done  = close_done_q;
  end

endmodule

// File: tb/tb_door_ctrl.sv
// Directed bench for door_ctrl with STEP_CYCLES=4, HOLD_CYCLES=10.
module tb_door_ctrl;
  logic       clk = 1'b0;
  logic       rst, open_req, reopen_btn, close_btn, moving;
  logic [1:0] dispStage;
  logic       door_closed, close_done;

  int total = 0;
  int bad   = 0;
  int e     = 0;

  door_ctrl #(.STEP_CYCLES(4), .HOLD_CYCLES(10)) dut (
    .clk        (clk),
    .rst        (rst),
    .open_req   (open_req),
    .reopen_btn (reopen_btn),
    .close_btn  (close_btn),
    .moving     (moving),
    .dispStage  (dispStage),
    .door_closed(door_closed),
    .close_done (close_done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    e++;
  endtask

  // observed word = {dispStage, door_closed, close_done}
  task automatic chk(input string tag, input logic [3:0] expv);
    logic [3:0] obs;
    obs = {dispStage, door_closed, close_done};
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s edge=%0d observed=%b expected=%b", tag, e, obs, expv);
    end
  endtask

  task automatic at(input int k, input logic [3:0] expv, input string tag);
    while (e < k) tick();
    chk(tag, expv);
  endtask

  // Leaves e=-1 so that the next tick is edge 0.
  task automatic do_reset();
    rst = 1'b1; open_req = 1'b0; reopen_btn = 1'b0; close_btn = 1'b0; moving = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    e = -1;
  endtask

  task automatic start_open();
    open_req = 1'b1;
    tick();
    open_req = 1'b0;
  endtask

  initial begin
    // Nominal cycle
    do_reset();
    chk("reset", 4'b0010);
    start_open();
    chk("nom_open0", 4'b0000);
    at(3,  4'b0000, "nom3");
    at(4,  4'b0100, "nom4");
    at(8,  4'b1000, "nom8");
    at(11, 4'b1000, "nom11");
    at(12, 4'b1100, "nom12");
    at(25, 4'b1100, "nom25");
    at(26, 4'b1000, "nom26");
    at(30, 4'b0100, "nom30");
    at(33, 4'b0100, "nom33");
    at(34, 4'b0011, "nom34_done");
    at(35, 4'b0010, "nom35_pulse_end");

    // Motion interlock
    do_reset();
    moving = 1'b1; open_req = 1'b1;
    at(0,  4'b0010, "mov0");
    at(25, 4'b0010, "mov25");
    at(50, 4'b0010, "mov50");
    moving = 1'b0;
    at(51, 4'b0000, "mov51_open");
    open_req = 1'b0;
    at(54, 4'b0000, "mov54");
    at(55, 4'b0100, "mov55");

    // Reopen while closing
    do_reset();
    start_open();
    at(30, 4'b0100, "reo30");
    reopen_btn = 1'b1;
    tick();
    reopen_btn = 1'b0;
    chk("reo31", 4'b0100);
    at(34, 4'b0100, "reo34");
    at(35, 4'b1000, "reo35");
    at(38, 4'b1000, "reo38");
    at(39, 4'b1100, "reo39");
    at(52, 4'b1100, "reo52");
    at(53, 4'b1000, "reo53");
    at(61, 4'b0011, "reo61_done");

    // Close button in HOLD
    do_reset();
    start_open();
    at(14, 4'b1100, "cb14");
    close_btn = 1'b1;
    tick();
    close_btn = 1'b0;
    at(18, 4'b1100, "cb18");
    at(19, 4'b1000, "cb19");
    at(23, 4'b0100, "cb23");
    at(26, 4'b0100, "cb26");
    at(27, 4'b0011, "cb27_done");
    at(28, 4'b0010, "cb28");

    // Simultaneous reopen and close in HOLD
    do_reset();
    start_open();
    at(19, 4'b1100, "sim19");
    reopen_btn = 1'b1; close_btn = 1'b1;
    tick();
    reopen_btn = 1'b0; close_btn = 1'b0;
    chk("sim20", 4'b1100);
    at(26, 4'b1100, "sim26");
    at(33, 4'b1100, "sim33");
    at(34, 4'b1000, "sim34");
    at(41, 4'b0100, "sim41");
    at(42, 4'b0011, "sim42_done");

    // Reset mid-operation
    do_reset();
    start_open();
    at(8, 4'b1000, "rst8");
    rst = 1'b1; open_req = 1'b1;
    tick();
    chk("rst9", 4'b0010);
    rst = 1'b0;
    tick();
    chk("rst10_open", 4'b0000);
    open_req = 1'b0;
    at(13, 4'b0000, "rst13");
    at(14, 4'b0100, "rst14");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
